// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state codes,
// opcodes, datapath select encodings and the control-vector bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC      = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_WB   = 4'd10
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// Combinational map from FSM state (plus mem_ready in FETCH) to the
// datapath control vector; unlisted signals and unused states give all zeros.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // PC and IR only latch on the cycle the instruction word actually arrives
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALU_ADD;
      end
      MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: holds the state register and next-state logic,
// and gates the decoded control vector with reset.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           i_or_d,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           bad_op,
  output logic [3:0]     state_o
);

  state_t state_q;
  ctrl_t  ctrl_dec;
  ctrl_t  ctrl_out;
  logic   op_known;

  assign op_known = (opcode == OP_R)  || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:     state_q <= mem_ready ? DECODE : FETCH;
        DECODE: begin
          if (opcode == OP_LW || opcode == OP_SW || opcode == OP_ADDI)
            state_q <= MEM_ADDR;
          else if (opcode == OP_R)
            state_q <= EXEC;
          else if (opcode == OP_BEQ)
            state_q <= BRANCH;
          else if (opcode == OP_J)
            state_q <= JUMP;
          else
            state_q <= FETCH;
        end
        MEM_ADDR: begin
          // Opcode is re-examined here; anything unexpected restarts from fetch
          if (opcode == OP_LW)
            state_q <= MEM_READ;
          else if (opcode == OP_SW)
            state_q <= MEM_WRITE;
          else if (opcode == OP_ADDI)
            state_q <= ADDI_WB;
          else
            state_q <= FETCH;
        end
        MEM_READ:  state_q <= mem_ready ? MEM_WB : MEM_READ;
        MEM_WRITE: state_q <= mem_ready ? FETCH : MEM_WRITE;
        EXEC:      state_q <= R_WB;
        default:   state_q <= FETCH;
      endcase
    end
  end

  mc_out_decode u_out_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_dec)
  );

  // Reset must suppress any write strobe from the state being left behind
  assign ctrl_out = reset ? '0 : ctrl_dec;

  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign i_or_d        = ctrl_out.i_or_d;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign ir_write      = ctrl_out.ir_write;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign reg_dst       = ctrl_out.reg_dst;
  assign reg_write     = ctrl_out.reg_write;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_op        = ctrl_out.alu_op;
  assign pc_source     = ctrl_out.pc_source;

  assign bad_op  = !reset && (state_q == DECODE) && !op_known;
  assign state_o = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a directed vector table, then random instruction
// streams checked against an instruction-level step model.
module tb_mc_control_fsm;

  localparam logic [5:0] OR_   = 6'b000000;
  localparam logic [5:0] OLW   = 6'b100011;
  localparam logic [5:0] OSW   = 6'b101011;
  localparam logic [5:0] OBEQ  = 6'b000100;
  localparam logic [5:0] OJ    = 6'b000010;
  localparam logic [5:0] OADDI = 6'b001000;
  localparam logic [5:0] OBAD  = 6'b111111;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  typedef struct packed {
    logic       pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, psrc;
    logic       bad;
    logic [3:0] st;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    obs_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = OR_;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, bad_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;

  int total = 0;
  int bad = 0;
  int rw_seen = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  mc_control_fsm #(.OPW(6)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .bad_op(bad_op), .state_o(state_o)
  );

  // Expected outputs for one cycle in a given state, straight from the state table
  function automatic obs_t exp_for(input int st, input logic rdy, input logic b);
    obs_t e;
    e = '0;
    e.st = st[3:0];
    case (st)
      0:  begin e.pcw = rdy; e.irw = rdy; e.mr = 1'b1; e.asb = 2'b01; end
      1:  begin e.asb = 2'b11; e.bad = b; end
      2:  begin e.asa = 1'b1; e.asb = 2'b10; end
      3:  begin e.mr = 1'b1; e.iod = 1'b1; end
      4:  begin e.m2r = 1'b1; e.rw = 1'b1; end
      5:  begin e.mw = 1'b1; e.iod = 1'b1; end
      6:  begin e.asa = 1'b1; e.aop = 2'b10; end
      7:  begin e.rd = 1'b1; e.rw = 1'b1; end
      8:  begin e.asa = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1; e.psrc = 2'b01; end
      9:  begin e.pcw = 1'b1; e.psrc = 2'b10; end
      10: begin e.rw = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic obs_t observe();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source, bad_op, state_o};
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic y, input int s, input logic b);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = y;
    v.exp = r ? obs_t'('0) : exp_for(s, y, b);
    tv.push_back(v);
  endtask

  task automatic check(input string name, input obs_t got, input obs_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // One clock: drive inputs, sample mid-cycle, then cross the rising edge
  task automatic cycle(input logic r, input logic [5:0] o, input logic y, input obs_t want, input string name);
    obs_t got;
    reset = r; opcode = o; mem_ready = y;
    @(negedge clk);
    got = observe();
    if (got.rw) rw_seen++;
    check(name, got, want);
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_valid(input logic [5:0] o);
    return o == OR_ || o == OLW || o == OSW || o == OBEQ || o == OJ || o == OADDI;
  endfunction

  initial begin
    // Directed table: reset, R, LW with waits, SW, BEQ, J, fetch waits + ADDI, bad op
    add(T, OR_, T, 0, F); add(T, OR_, T, 0, F);
    add(F, OR_, T, 0, F); add(F, OR_, T, 1, F); add(F, OBAD, F, 6, F); add(F, OJ, T, 7, F);
    add(F, OLW, T, 0, F); add(F, OLW, T, 1, F); add(F, OLW, T, 2, F);
    add(F, OR_, F, 3, F); add(F, OR_, F, 3, F); add(F, OR_, F, 3, F);
    add(F, OR_, T, 3, F); add(F, OLW, T, 4, F);
    add(F, OSW, T, 0, F); add(F, OSW, T, 1, F); add(F, OSW, T, 2, F); add(F, OSW, T, 5, F);
    add(F, OBEQ, T, 0, F); add(F, OBEQ, T, 1, F); add(F, OBEQ, T, 8, F);
    add(F, OJ, T, 0, F); add(F, OJ, T, 1, F); add(F, OJ, T, 9, F);
    add(F, OADDI, F, 0, F); add(F, OADDI, F, 0, F); add(F, OADDI, T, 0, F);
    add(F, OADDI, T, 1, F); add(F, OADDI, T, 2, F); add(F, OADDI, T, 10, F);
    add(F, OBAD, T, 0, F); add(F, OBAD, T, 1, T);
    // Reset landing in MEM_WB and in a MEM_WRITE wait
    add(F, OLW, T, 0, F); add(F, OLW, T, 1, F); add(F, OLW, T, 2, F); add(F, OLW, T, 3, F);
    add(T, OLW, T, 0, F); add(F, OLW, F, 0, F); add(F, OSW, T, 0, F);
    add(F, OSW, T, 1, F); add(F, OSW, T, 2, F); add(F, OSW, F, 5, F);
    add(T, OSW, F, 0, F); add(F, OR_, T, 0, F); add(T, OR_, T, 0, F);

    for (int i = 0; i < tv.size(); i++)
      cycle(tv[i].rst, tv[i].op, tv[i].rdy, tv[i].exp, $sformatf("vec[%0d]", i));

    // Random instruction stream against the step model
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      int steps[$];
      int cycles;
      int sel;
      sel = $urandom_range(0, 6);
      case (sel)
        0: op = OR_;  1: op = OLW; 2: op = OSW; 3: op = OBEQ;
        4: op = OJ;   5: op = OADDI;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (is_valid(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      steps = {0, 1};
      case (op)
        OR_:   steps = {steps, 6, 7};
        OLW:   steps = {steps, 2, 3, 4};
        OSW:   steps = {steps, 2, 5};
        OBEQ:  steps = {steps, 8};
        OJ:    steps = {steps, 9};
        OADDI: steps = {steps, 2, 10};
        default: ;
      endcase
      rw_seen = 0;
      cycles = 0;
      foreach (steps[k]) begin
        int s;
        logic [5:0] drv;
        s = steps[k];
        // Opcode only matters in DECODE and MEM_ADDR; scramble it elsewhere
        drv = (s == 1 || s == 2) ? op : 6'($urandom_range(0, 63));
        if (s == 0 || s == 3 || s == 5) begin
          int waits;
          logic rdy;
          waits = 0;
          do begin
            rdy = ($urandom_range(0, 2) != 0) || (waits >= 6);
            cycle(F, drv, rdy, exp_for(s, rdy, F), $sformatf("rnd%0d.st%0d", n, s));
            cycles++;
            waits++;
          end while (!rdy);
        end else begin
          logic rdy;
          rdy = 1'($urandom_range(0, 1));
          cycle(F, drv, rdy, exp_for(s, rdy, (s == 1) && !is_valid(op)),
                $sformatf("rnd%0d.st%0d", n, s));
          cycles++;
        end
      end
      total++;
      if (rw_seen != ((op == OR_ || op == OLW || op == OADDI) ? 1 : 0)) begin
        bad++;
        $display("FAIL rw_count insn %0d op=%b got=%0d want=%0d", n, op, rw_seen,
                 (op == OR_ || op == OLW || op == OADDI) ? 1 : 0);
      end
      $display("insn %0d op=%b cycles=%0d", n, op, cycles);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
